adder_arb_ctrl_26b: RTL and testbench

Sequencing controller and round-robin arbiter that shares one registered 26-bit adder datapath among N_REQ requesters. Each requester presents operands with a request. The block grants one requester at a time, drives the shared adder, and waits out the adder latency. It then returns the 27-bit sum tagged with the requester index over a valid/ready handshake. It sits between the requester-side control logic and the adder datapath; one operation is in flight at a time.

---
 rtl/adder_arb_pkg.sv | 18 +
 rtl/adder_core_26b.sv | 45 ++++
 rtl/adder_arb_ctrl_26b.sv | 121 ++++++++++++
 tb/tb_adder_arb_ctrl_26b.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared FSM state type, default sizes and ID width helper
package adder_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 26;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_core_26b.sv
// rtl/adder_core_26b.sv - registered W-bit adder, input and output registers, latency 2
// Load enables let the controller hold the result in the output register while RESP stalls.
module adder_core_26b
   import adder_arb_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_en,
   input  logic         out_en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W:0]   sum
);

   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic         cin_q;
   logic [W:0]   sum_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
      end else if (in_en) begin
         a_q   <= a;
         b_q   <= b;
         cin_q <= cin;
      end
   end

   assign sum_c = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (out_en) begin
         sum <= sum_c;
      end
   end

endmodule

// File: rtl/adder_arb_ctrl_26b.sv
// rtl/adder_arb_ctrl_26b.sv - arbiter and sequencer sharing one registered adder among N_REQ requesters
// ADDER_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module adder_arb_ctrl_26b
   import adder_arb_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   parameter  int W     = W_DEF,
   localparam int IW    = id_width(N_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] a_in,
   input  logic [N_REQ*W-1:0] b_in,
   input  logic [N_REQ-1:0]   cin,
   output logic [N_REQ-1:0]   gnt,
   output logic               res_valid,
   output logic [W:0]         res_sum,
   output logic [IW-1:0]      res_id,
   input  logic               res_ready,
   output logic               busy
);

   arb_state_e       state_q;
   arb_state_e       state_d;
   logic             issue_start;
   logic             win_any;
   logic [IW-1:0]    win_idx;
   logic [N_REQ-1:0] win_oh;
   int               pos;
   logic [W-1:0]     a_sel;
   logic [W-1:0]     b_sel;
   logic             cin_sel;

`ifdef ADDER_ARB_RR_EN
   logic [IW-1:0] rr_ptr;

   // Pointer holds the last winner so the search resumes just past it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= IW'(N_REQ - 1);
      end else if (issue_start) begin
         rr_ptr <= win_idx;
      end
   end
`endif

   always_comb begin
      win_any = 1'b0;
      win_idx = '0;
      win_oh  = '0;
      pos     = 0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef ADDER_ARB_RR_EN
         pos = (int'(rr_ptr) + 1 + k) % N_REQ;
`else
         pos = k;
`endif
         if (!win_any && req[pos]) begin
            win_any     = 1'b1;
            win_idx     = IW'(pos);
            win_oh[pos] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      issue_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               state_d     = ISSUE;
               issue_start = 1'b1;
            end
         end
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = RESP;
         RESP:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // res_id doubles as the operand-mux select while the operation is in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         gnt       <= '0;
         res_id    <= '0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy      <= (state_d != IDLE);
         res_valid <= (state_d == RESP);
         gnt       <= '0;
         if (issue_start) begin
            gnt    <= win_oh;
            res_id <= win_idx;
         end
      end
   end

   assign a_sel   = a_in[int'(res_id)*W +: W];
   assign b_sel   = b_in[int'(res_id)*W +: W];
   assign cin_sel = cin[res_id];

   adder_core_26b #(
      .W (W)
   ) u_core (
      .clk    (clk),
      .reset  (reset),
      .in_en  (state_q == ISSUE),
      .out_en (state_q == WAIT),
      .a      (a_sel),
      .b      (b_sel),
      .cin    (cin_sel),
      .sum    (res_sum)
   );

endmodule

// File: tb/tb_adder_arb_ctrl_26b.sv
// tb/tb_adder_arb_ctrl_26b.sv - scoreboard bench for adder_arb_ctrl_26b
module tb_adder_arb_ctrl_26b;

   localparam int N = 4;
   localparam int W = 26;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] a_in = '0;
   logic [N*W-1:0] b_in = '0;
   logic [N-1:0]   cin = '0;
   logic           res_ready = 1'b1;
   logic [N-1:0]   gnt;
   logic           res_valid;
   logic [W:0]     res_sum;
   logic [1:0]     res_id;
   logic           busy;

   int checks = 0;
   int errors = 0;

   logic [W:0] exp_sum_q[$];
   logic [1:0] exp_id_q[$];

   adder_arb_ctrl_26b #(.N_REQ(N), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .cin       (cin),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_sum   (res_sum),
      .res_id    (res_id),
      .res_ready (res_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      longint s;
      s = longint'(a) + longint'(b) + longint'(c);
      return s[W:0];
   endfunction

   always @(negedge clk) begin
      if (reset && res_valid && res_ready) begin
         if (exp_sum_q.size() == 0) begin
            check("sb_unexpected", 1, 0);
         end else begin
            check("sb_sum", res_sum, exp_sum_q.pop_front());
            check("sb_id", res_id, exp_id_q.pop_front());
         end
      end
   end

   task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W:0] exp, input int stall);
      int other;
      other = (id + 1) % N;
      @(posedge clk); #1;
      a_in[id*W +: W] = a;
      b_in[id*W +: W] = b;
      cin[id]         = c;
      req[id]         = 1'b1;
      res_ready       = (stall == 0);
      exp_sum_q.push_back(exp);
      exp_id_q.push_back(2'(id));
      @(negedge clk); check("idle_gnt", gnt, 0);
      @(negedge clk); check("gnt", gnt, 4'b0001 << id); check("issue_busy", busy, 1);
      req[id] = 1'b0;
      @(negedge clk); check("wait_valid", res_valid, 0);
      @(negedge clk); check("resp_valid", res_valid, 1);
      if (stall > 0) begin
         req[other] = 1'b1;
         repeat (stall) begin
            @(negedge clk);
            check("bp_valid", res_valid, 1);
            check("bp_sum", res_sum, exp);
            check("bp_id", res_id, id);
            check("bp_gnt", gnt, 0);
         end
         @(posedge clk); #1;
         req[other] = 1'b0;
         res_ready  = 1'b1;
         @(negedge clk);
      end
      @(negedge clk); check("done_busy", busy, 0); check("done_valid", res_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_valid", res_valid, 0);
      check("rst_sum", res_sum, 0);
      check("rst_id", res_id, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      repeat (10) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_gnt0", gnt, 0);
         check("idle_valid", res_valid, 0);
      end

      do_op(1, 26'h0000005, 26'h0000003, 1'b0, 27'h0000008, 0);
      do_op(0, 26'h3FFFFFF, 26'h0000001, 1'b0, 27'h4000000, 0);
      do_op(0, 26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 27'h7FFFFFF, 0);
      do_op(3, 26'h2000000, 26'h2000000, 1'b0, 27'h4000000, 0);
      do_op(2, 26'h1234567, 26'h0ABCDEF, 1'b1, 27'h1CF1357, 5);

      // Reset while the operation sits in WAIT.
      @(posedge clk); #1;
      a_in[2*W +: W] = 26'h0000015;
      b_in[2*W +: W] = 26'h0000001;
      req[2] = 1'b1;
      @(negedge clk);
      @(negedge clk); check("mid_gnt", gnt, 4'b0100);
      req[2] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_gnt", gnt, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_sum", res_sum, 0);
      check("mid_rst_id", res_id, 0);
      check("mid_rst_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      do_op(3, 26'h0000010, 26'h0000020, 1'b1, 27'h0000031, 0);

      // Contention with all requests held.
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         a_in[i*W +: W] = 26'(i * 26'h0101010 + 7);
         b_in[i*W +: W] = 26'(26'h3FFFFF0 + i);
         cin[i]         = 1'(i);
      end
      reset     = 1'b1;
      res_ready = 1'b1;
      req       = '1;
      for (int g = 0; g < 5; g++) begin
         int waited;
         int eg;
         waited = 0;
         @(negedge clk);
         while (gnt == 0 && waited < 8) begin
            @(negedge clk);
            waited++;
         end
         if (gnt == 0) begin
            check("cont_timeout", 0, 1);
            break;
         end
`ifdef ADDER_ARB_RR_EN
         eg = g % N;
`else
         eg = 0;
`endif
         check("cont_gnt", gnt, 4'b0001 << eg);
         exp_sum_q.push_back(add_ref(a_in[eg*W +: W], b_in[eg*W +: W], cin[eg]));
         exp_id_q.push_back(2'(eg));
         if (g > 0) check("cont_gap", waited + 1, 4);
      end
      req = '0;
      repeat (6) @(negedge clk);
      check("sb_drained", exp_sum_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
